// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM read-port arbiter.
// Latency: n/a (types and a combinational round-robin picker only).
// Backpressure: n/a.
package jtframe_sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RDY
    } state_t;

    // Widest requester vector the picker handles; callers zero-extend.
    localparam int MAXSLOT = 8;

    // Round-robin search starting just after 'last'. Returns the found flag;
    // the chosen slot index comes back through 'idx' (0 when nothing found).
    function automatic logic rr_pick(
        input  logic [MAXSLOT-1:0] req,
        input  int                 last,
        input  int                 nslot,
        output int                 idx
    );
        logic found;
        int   j;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= MAXSLOT; k++) begin
            if (k <= nslot && !found) begin
                j = (last + k) % nslot;
                if (req[j]) begin
                    found = 1'b1;
                    idx   = j;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/jtframe_sdram_arb_cache.sv
// One-entry read cache for a single ROM slot: tag/data/valid, hit detect, slot_ok/slot_dout.
// Latency: ok rises 1 cycle after a hit, or in the cycle right after a matching fill.
// Backpressure: none; fill and flush are single-cycle strobes from the arbiter FSM.
// Ports: clk, rst_n, flush (invalidate), fill/fill_tag/fill_data (write entry),
//        cs/addr (slot request), hit (comb), ok/dout (registered slot outputs).
module jtframe_sdram_arb_cache
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          fill,
    input  logic [AW-1:0] fill_tag,
    input  logic [DW-1:0] fill_data,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic [AW-1:0] tag;
    logic          valid;

    assign hit = cs && valid && (tag == addr);

    // dout doubles as the data store, so it always shows the cached word.
    // A fill is forwarded into ok so the requester sees data one cycle after
    // data_rdy rather than two; a fill with a stale tag never raises ok.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag   <= '0;
            valid <= 1'b0;
            ok    <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ok    <= 1'b0;
        end else begin
            if (fill) begin
                tag   <= fill_tag;
                valid <= 1'b1;
                dout  <= fill_data;
            end
            ok <= cs && (fill ? (fill_tag == addr) : hit);
        end
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among NSLOT ROM slots, each with a one-entry cache.
// Latency: request issues 1 cycle after a miss is visible; slot_ok the cycle after data_rdy.
// Backpressure: sdram_req held until sdram_ack; no grants while downloading; loop_rst aborts.
// Ports: clk, rst_n, loop_rst, downloading, slot_cs/slot_addr/slot_ok/slot_dout (per slot),
//        sdram_req/sdram_addr/sdram_ack/data_rdy/data_read (controller side), refresh_en.
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int                   NSLOT   = 4,
    parameter int                   AW      = 22,
    parameter int                   DW      = 32,
    parameter logic [NSLOT*AW-1:0]  OFFSETS = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                loop_rst,
    input  logic                downloading,
    input  logic [NSLOT-1:0]    slot_cs,
    input  logic [NSLOT*AW-1:0] slot_addr,
    output logic [NSLOT-1:0]    slot_ok,
    output logic [NSLOT*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    localparam int GW = $clog2(NSLOT);

    state_t         state;
    logic [GW-1:0]  gnt;
    logic [GW-1:0]  last;
    logic [AW-1:0]  gnt_addr;
    logic           dl_d;

    logic [NSLOT-1:0] hit;
    logic [NSLOT-1:0] miss;
    logic [NSLOT-1:0] fill;
    logic [AW-1:0]    addr_a [NSLOT];
    logic [AW-1:0]    off_a  [NSLOT];

    logic           pick_found;
    int             pick_int;
    logic [GW-1:0]  pick_idx;
    logic           issue;
    logic           fill_any;
    logic           flush;

    assign miss = slot_cs & ~hit;

    always_comb begin
        pick_int   = 0;
        pick_found = rr_pick(MAXSLOT'(miss), int'(last), NSLOT, pick_int);
    end

    assign pick_idx = GW'(pick_int);
    assign issue    = (state == IDLE) && !loop_rst && !downloading && pick_found;
    assign refresh_en = (state == IDLE) && !issue;

    // Data arriving together with the ack is accepted as ack-then-rdy.
    assign fill_any = !loop_rst && data_rdy &&
                      ((state == WAIT_RDY) || (state == WAIT_ACK && sdram_ack));

    // Caches may hold pre-download contents; drop them when the load ends.
    assign flush = loop_rst || (dl_d && !downloading);

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        assign addr_a[i] = slot_addr[i*AW +: AW];
        assign off_a[i]  = OFFSETS[i*AW +: AW];
        assign fill[i]   = fill_any && (gnt == GW'(i));

        jtframe_sdram_arb_cache #(
            .AW (AW),
            .DW (DW)
        ) u_cache (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .fill      (fill[i]),
            .fill_tag  (gnt_addr),
            .fill_data (data_read),
            .cs        (slot_cs[i]),
            .addr      (addr_a[i]),
            .hit       (hit[i]),
            .ok        (slot_ok[i]),
            .dout      (slot_dout[i*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            gnt        <= '0;
            gnt_addr   <= '0;
            last       <= GW'(NSLOT-1);
            dl_d       <= 1'b0;
        end else begin
            dl_d <= downloading;
            if (loop_rst) begin
                state     <= IDLE;
                sdram_req <= 1'b0;
                last      <= GW'(NSLOT-1);
            end else begin
                case (state)
                    IDLE: begin
                        if (issue) begin
                            gnt        <= pick_idx;
                            // Tag keeps the slot-relative address; the bus gets the offset one.
                            gnt_addr   <= addr_a[pick_idx];
                            sdram_addr <= addr_a[pick_idx] + off_a[pick_idx];
                            sdram_req  <= 1'b1;
                            state      <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (sdram_ack) begin
                            sdram_req <= 1'b0;
                            if (data_rdy) begin
                                last  <= gnt;
                                state <= IDLE;
                            end else begin
                                state <= WAIT_RDY;
                            end
                        end
                    end
                    WAIT_RDY: begin
                        if (data_rdy) begin
                            last  <= gnt;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed bench for jtframe_sdram_arb: miss/hit timing, round robin, in-flight changes, abort, download hold.
// Latency: n/a (testbench).
// Backpressure: bench plays the SDRAM controller, answering ack/rdy at chosen cycles.
module tb_jtframe_sdram_arb;

    localparam int NSLOT = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;
    localparam logic [NSLOT*AW-1:0] OFFS = {22'h0, 22'h4000, 22'h8000, 22'h0};

    logic                clk;
    logic                rst_n;
    logic                loop_rst;
    logic                downloading;
    logic [NSLOT-1:0]    slot_cs;
    logic [NSLOT*AW-1:0] slot_addr;
    logic [NSLOT-1:0]    slot_ok;
    logic [NSLOT*DW-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [DW-1:0]       data_read;
    logic                refresh_en;

    logic [AW-1:0] addr [NSLOT];
    assign slot_addr = {addr[3], addr[2], addr[1], addr[0]};

    int checks = 0;
    int errors = 0;

    jtframe_sdram_arb #(
        .NSLOT   (NSLOT),
        .AW      (AW),
        .DW      (DW),
        .OFFSETS (OFFS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .loop_rst    (loop_rst),
        .downloading (downloading),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dout_of(input int i);
        return slot_dout[i*DW +: DW];
    endfunction

    task automatic wait_req(input string tag, output logic [AW-1:0] a);
        int n;
        n = 0;
        while (!sdram_req && n < 20) begin
            cyc(1);
            n++;
        end
        chk(tag, sdram_req, 1'b1);
        a = sdram_addr;
    endtask

    // Acknowledge the pending request, then return data the next cycle.
    task automatic serve(input logic [DW-1:0] d);
        sdram_ack = 1'b1;
        cyc(1);
        sdram_ack = 1'b0;
        data_rdy  = 1'b1;
        data_read = d;
        cyc(1);
        data_rdy  = 1'b0;
    endtask

    task automatic do_access(input string tag, input logic [DW-1:0] d, output logic [AW-1:0] a);
        wait_req(tag, a);
        serve(d);
    endtask

    logic [AW-1:0] a;
    logic [AW-1:0] exp_rr [4];
    bit            seen;

    initial begin
        rst_n = 1'b0; loop_rst = 1'b0; downloading = 1'b0;
        slot_cs = '0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        for (int i = 0; i < NSLOT; i++) addr[i] = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // Reset values
        chk("rst_req", sdram_req, 1'b0);
        chk("rst_addr", sdram_addr, '0);
        chk("rst_ok", slot_ok, '0);
        chk("rst_dout", slot_dout[63:0], '0);
        chk("rst_refresh", refresh_en, 1'b1);

        // Single miss on slot1: request at +1, ack at +3, rdy at +6, ok at +7
        slot_cs[1] = 1'b1; addr[1] = 22'h100;
        #1 chk("miss_refresh", refresh_en, 1'b0);
        cyc(1);
        chk("miss_req", sdram_req, 1'b1);
        chk("miss_addr", sdram_addr, 22'h8100);
        cyc(2);
        sdram_ack = 1'b1;
        cyc(1);
        sdram_ack = 1'b0;
        chk("miss_req_drop", sdram_req, 1'b0);
        cyc(2);
        data_rdy = 1'b1; data_read = 32'hCAFEBABE;
        chk("miss_ok_early", slot_ok[1], 1'b0);
        cyc(1);
        data_rdy = 1'b0;
        chk("miss_ok", slot_ok[1], 1'b1);
        chk("miss_dout", dout_of(1), 32'hCAFEBABE);

        // Hit: drop and reassert cs with the same address
        slot_cs[1] = 1'b0;
        cyc(1);
        chk("hit_ok_drop", slot_ok[1], 1'b0);
        slot_cs[1] = 1'b1;
        cyc(1);
        chk("hit_ok", slot_ok[1], 1'b1);
        chk("hit_noreq", sdram_req, 1'b0);
        chk("hit_refresh", refresh_en, 1'b1);

        // Round robin: loop_rst puts last back at 3, then all four miss
        slot_cs = '0;
        loop_rst = 1'b1;
        cyc(1);
        loop_rst = 1'b0;
        addr[0] = 22'h10; addr[1] = 22'h20; addr[2] = 22'h30; addr[3] = 22'h40;
        slot_cs = 4'hF;
        exp_rr[0] = 22'h10; exp_rr[1] = 22'h8020; exp_rr[2] = 22'h4030; exp_rr[3] = 22'h40;
        for (int k = 0; k < 4; k++) begin
            do_access("rr_req", 32'hA000_0000 + 32'(k), a);
            chk($sformatf("rr_addr%0d", k), a, exp_rr[k]);
        end
        chk("rr_ok_all", slot_ok, 4'hF);
        chk("rr_dout2", dout_of(2), 32'hA000_0002);

        // slot0 and slot2 re-miss with last=3: order 0 then 2
        addr[0] = 22'h11; addr[2] = 22'h31;
        do_access("rr2_req0", 32'hB000_0000, a);
        chk("rr2_addr0", a, 22'h11);
        do_access("rr2_req1", 32'hB000_0002, a);
        chk("rr2_addr1", a, 22'h4031);
        chk("rr2_ok", slot_ok, 4'hF);

        // Address change while the access is in flight
        addr[2] = 22'h10;
        wait_req("chg_req", a);
        chk("chg_addr", a, 22'h4010);
        sdram_ack = 1'b1;
        cyc(1);
        sdram_ack = 1'b0;
        addr[2] = 22'h20;
        cyc(1);
        data_rdy = 1'b1; data_read = 32'h1111_0010;
        cyc(1);
        data_rdy = 1'b0;
        chk("chg_no_ok", slot_ok[2], 1'b0);
        do_access("chg_req2", 32'h2222_0020, a);
        chk("chg_addr2", a, 22'h4020);
        chk("chg_ok2", slot_ok[2], 1'b1);
        chk("chg_dout2", dout_of(2), 32'h2222_0020);

        // ack and data_rdy in the same cycle
        addr[3] = 22'h41;
        wait_req("both_req", a);
        chk("both_addr", a, 22'h41);
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h3333_0041;
        cyc(1);
        sdram_ack = 1'b0; data_rdy = 1'b0;
        chk("both_ok", slot_ok[3], 1'b1);
        chk("both_dout", dout_of(3), 32'h3333_0041);
        chk("both_req_low", sdram_req, 1'b0);
        #1 chk("both_refresh", refresh_en, 1'b1);

        // loop_rst while waiting for data, then a late data_rdy
        addr[0] = 22'h12;
        wait_req("lr_req", a);
        sdram_ack = 1'b1;
        cyc(1);
        sdram_ack = 1'b0;
        loop_rst = 1'b1; slot_cs = '0;
        cyc(1);
        loop_rst = 1'b0;
        chk("lr_req_low", sdram_req, 1'b0);
        chk("lr_ok_low", slot_ok, '0);
        #1 chk("lr_idle", refresh_en, 1'b1);
        data_rdy = 1'b1; data_read = 32'hDEAD_BEEF;
        cyc(1);
        data_rdy = 1'b0;
        chk("lr_late_ok", slot_ok, '0);
        chk("lr_late_req", sdram_req, 1'b0);
        // Previously cached addresses must now miss
        addr[0] = 22'h11;
        slot_cs = 4'hF;
        cyc(1);
        chk("lr_inval_ok", slot_ok, '0);
        chk("lr_inval_req", sdram_req, 1'b1);
        slot_cs = '0;
        loop_rst = 1'b1;
        cyc(1);
        loop_rst = 1'b0;

        // Download hold
        downloading = 1'b1;
        slot_cs[0] = 1'b1; addr[0] = 22'h50;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("dl_noreq", sdram_req, 1'b0);
            chk("dl_refresh", refresh_en, 1'b1);
        end
        downloading = 1'b0;
        #1 chk("dl_issue_refresh", refresh_en, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!seen) begin
                cyc(1);
                seen = sdram_req;
            end
        end
        chk("dl_req_2cyc", seen, 1'b1);
        chk("dl_addr", sdram_addr, 22'h50);
        serve(32'h5555_0050);
        chk("dl_ok", slot_ok[0], 1'b1);
        chk("dl_dout", dout_of(0), 32'h5555_0050);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
